// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand/handshake bus and result bus for alu_pipe.
// The zero signal exists only when ALU_PIPE_ZERO_FLAG_EN is defined.
interface alu_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] xin;
  logic [WIDTH-1:0] yin;
  logic             carry_in;
  logic             end_bar;
  logic             cmpl_x;
  logic             cmpl_y;
  logic             op_and;
  logic             op_xor;
  logic             op_arith;
  logic             out_valid;
  logic [WIDTH-1:0] zout;
  logic             overflow;
  logic             carry_out;
`ifdef ALU_PIPE_ZERO_FLAG_EN
  logic             zero;
`endif

  modport master (
`ifdef ALU_PIPE_ZERO_FLAG_EN
    input  zero,
`endif
    output in_valid, xin, yin, carry_in, end_bar,
    output cmpl_x, cmpl_y, op_and, op_xor, op_arith,
    input  in_ready, out_valid, zout, overflow, carry_out
  );

  modport slave (
`ifdef ALU_PIPE_ZERO_FLAG_EN
    output zero,
`endif
    input  in_valid, xin, yin, carry_in, end_bar,
    input  cmpl_x, cmpl_y, op_and, op_xor, op_arith,
    output in_ready, out_valid, zout, overflow, carry_out
  );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: digit-pipelined WIDTH-bit ALU, valid/ready in, multi-word carry chain.
// Define ALU_PIPE_ZERO_FLAG_EN to add the registered zero flag output.
module alu_pipe #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input logic       clk,
  input logic       rst,
  alu_pipe_if.slave bus
);
  localparam int S  = WIDTH / DIGIT;
  localparam int L  = S + 1;
  localparam int CW = $clog2(L + 1);

  typedef enum logic [1:0] {
    OP_NONE,
    OP_AND,
    OP_XOR,
    OP_ARITH
  } op_e;

  typedef struct packed {
    logic             v;
    op_e              op;
    logic             c;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] z;
  } stg_t;

  stg_t             pipe_q [S+1];
  stg_t             pipe_d [S+1];
  logic             chain_q, chain_d;
  logic [CW-1:0]    stall_q, stall_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] zout_q, zout_d;
  logic             ovf_q, ovf_d;
  logic             cout_q, cout_d;
`ifdef ALU_PIPE_ZERO_FLAG_EN
  logic             zero_q, zero_d;
`endif
  op_e              op_sel;
  logic             acc;

  assign bus.in_ready = ~rst & (stall_q == '0);
  assign acc          = bus.in_valid & bus.in_ready;

  // Resolve the op select: arith beats xor beats and.
  always_comb begin
    op_sel = OP_NONE;
    if (bus.op_arith)    op_sel = OP_ARITH;
    else if (bus.op_xor) op_sel = OP_XOR;
    else if (bus.op_and) op_sel = OP_AND;
  end

  // Stage 0 captures operands; stage k resolves digit k-1 and ripples carry.
  always_comb begin
    logic [DIGIT:0]   sum;
    logic [DIGIT-1:0] xd;
    logic [DIGIT-1:0] yd;
    logic [DIGIT-1:0] zd;
    sum = '0;
    xd  = '0;
    yd  = '0;
    zd  = '0;
    pipe_d[0].v  = acc;
    pipe_d[0].op = op_sel;
    pipe_d[0].c  = chain_q ? cout_q : bus.carry_in;
    pipe_d[0].x  = bus.xin ^ {WIDTH{bus.cmpl_x}};
    pipe_d[0].y  = bus.yin ^ {WIDTH{bus.cmpl_y}};
    pipe_d[0].z  = '0;
    for (int k = 1; k <= S; k++) begin
      pipe_d[k] = pipe_q[k-1];
      xd  = pipe_q[k-1].x[(k-1)*DIGIT +: DIGIT];
      yd  = pipe_q[k-1].y[(k-1)*DIGIT +: DIGIT];
      sum = {1'b0, xd} + {1'b0, yd}
          + {{DIGIT{1'b0}}, pipe_q[k-1].c};
      case (pipe_q[k-1].op)
        OP_ARITH: zd = sum[DIGIT-1:0];
        OP_XOR:   zd = xd ^ yd;
        OP_AND:   zd = xd & yd;
        default:  zd = '0;
      endcase
      pipe_d[k].z[(k-1)*DIGIT +: DIGIT] = zd;
      pipe_d[k].c = (pipe_q[k-1].op == OP_ARITH) & sum[DIGIT];
    end
  end

  // Output register loads on a finished word and otherwise holds.
  always_comb begin
    out_valid_d = pipe_q[S].v;
    zout_d      = zout_q;
    ovf_d       = ovf_q;
    cout_d      = cout_q;
`ifdef ALU_PIPE_ZERO_FLAG_EN
    zero_d      = zero_q;
`endif
    if (pipe_q[S].v) begin
      zout_d = pipe_q[S].z;
      cout_d = pipe_q[S].c;
      // carry into the MSB is recovered from the MSB sum bit
      ovf_d  = (pipe_q[S].op == OP_ARITH)
             & (pipe_q[S].x[WIDTH-1] ^ pipe_q[S].y[WIDTH-1]
              ^ pipe_q[S].z[WIDTH-1] ^ pipe_q[S].c);
`ifdef ALU_PIPE_ZERO_FLAG_EN
      zero_d = (pipe_q[S].z == '0);
`endif
    end
  end

  // Chain flag and the stall that waits for the chained carry.
  always_comb begin
    chain_d = chain_q;
    stall_d = (stall_q != '0) ? stall_q - CW'(1) : stall_q;
    if (acc) begin
      chain_d = (op_sel == OP_ARITH) & ~bus.end_bar;
      if (chain_d) stall_d = CW'(L);
    end
  end

  // State update with synchronous reset dropping all in-flight words.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= S; k++) pipe_q[k] <= '0;
      chain_q     <= 1'b0;
      stall_q     <= '0;
      out_valid_q <= 1'b0;
      zout_q      <= '0;
      ovf_q       <= 1'b0;
      cout_q      <= 1'b0;
`ifdef ALU_PIPE_ZERO_FLAG_EN
      zero_q      <= 1'b0;
`endif
    end else begin
      pipe_q      <= pipe_d;
      chain_q     <= chain_d;
      stall_q     <= stall_d;
      out_valid_q <= out_valid_d;
      zout_q      <= zout_d;
      ovf_q       <= ovf_d;
      cout_q      <= cout_d;
`ifdef ALU_PIPE_ZERO_FLAG_EN
      zero_q      <= zero_d;
`endif
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.zout      = zout_q;
  assign bus.overflow  = ovf_q;
  assign bus.carry_out = cout_q;
`ifdef ALU_PIPE_ZERO_FLAG_EN
  assign bus.zero      = zero_q;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: random + directed bench for alu_pipe against a word-level model.
// Build with ALU_PIPE_ZERO_FLAG_EN defined to also cover the zero flag.
module tb_alu_pipe;
  localparam int W = 8;
  localparam int L = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(W)) bus ();
  alu_pipe #(.WIDTH(W), .DIGIT(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [7:0] z;
    logic       ov;
    logic       co;
  } res_t;

  typedef struct {
    res_t r;
    logic zf;
    int   t;
  } obs_t;

  int   total = 0;
  int   bad = 0;
  int   t = 0;
  int   ready_from = 0;
  int   low_cnt = 0;
  bit   live = 0;
  bit   m_chain = 0;
  logic m_carry = 1'b0;
  res_t last = '{z: 8'h00, ov: 1'b0, co: 1'b0};
  res_t exp_at [int];
  obs_t obs_q [$];

  function automatic res_t calc(input logic [7:0] x, input logic [7:0] y,
                                input logic cx, input logic cy, input logic c,
                                input logic ar, input logic xo, input logic an);
    res_t r;
    logic [7:0] a;
    logic [7:0] b;
    int s;
    int ss;
    a = cx ? ~x : x;
    b = cy ? ~y : y;
    r = '{z: 8'h00, ov: 1'b0, co: 1'b0};
    if (ar) begin
      s  = int'(a) + int'(b) + int'(c);
      ss = int'($signed(a)) + int'($signed(b)) + int'(c);
      r.z  = s[7:0];
      r.co = (s > 255);
      r.ov = (ss > 127) || (ss < -128);
    end else if (xo) begin
      r.z = a ^ b;
    end else if (an) begin
      r.z = a & b;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", name, t, act, exp);
    end
  endtask

  // Model update and per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    res_t r;
    obs_t o;
    logic er;
    logic c;
    er = 1'b0;
    if (live) begin
      er = !rst && (t >= ready_from);
      chk("in_ready", bus.in_ready, er);
      if (exp_at.exists(t)) begin
        last = exp_at[t];
        exp_at.delete(t);
        chk("out_valid", bus.out_valid, 1);
        o.r.z  = bus.zout;
        o.r.ov = bus.overflow;
        o.r.co = bus.carry_out;
        o.zf   = 1'b0;
`ifdef ALU_PIPE_ZERO_FLAG_EN
        o.zf   = bus.zero;
`endif
        o.t    = t;
        obs_q.push_back(o);
      end else begin
        chk("out_valid", bus.out_valid, 0);
      end
      chk("zout", bus.zout, last.z);
      chk("overflow", bus.overflow, last.ov);
      chk("carry_out", bus.carry_out, last.co);
`ifdef ALU_PIPE_ZERO_FLAG_EN
      chk("zero", bus.zero, last.z == 8'h00);
`endif
      if (!bus.in_ready) low_cnt++;
    end
    if (rst) begin
      exp_at.delete();
      last = '{z: 8'h00, ov: 1'b0, co: 1'b0};
      m_chain = 0;
      ready_from = t + 1;
      live = 1;
    end else if (live && bus.in_valid && er) begin
      c = m_chain ? m_carry : bus.carry_in;
      r = calc(bus.xin, bus.yin, bus.cmpl_x, bus.cmpl_y, c,
               bus.op_arith, bus.op_xor, bus.op_and);
      exp_at[t + L + 1] = r;
      if (bus.op_arith && !bus.end_bar) begin
        m_chain = 1;
        m_carry = r.co;
        ready_from = t + L + 1;
      end else begin
        m_chain = 0;
      end
    end
    t++;
  end

  task automatic send(input logic [7:0] x, input logic [7:0] y,
                      input logic cx, input logic cy, input logic ci,
                      input logic eb, input logic ar, input logic xo,
                      input logic an);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.xin = x;
    bus.yin = y;
    bus.cmpl_x = cx;
    bus.cmpl_y = cy;
    bus.carry_in = ci;
    bus.end_bar = eb;
    bus.op_arith = ar;
    bus.op_xor = xo;
    bus.op_and = an;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 50);
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready low for %0d cycles", n);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t p;
    bus.in_valid = 1'b0;
    bus.xin = '0;
    bus.yin = '0;
    bus.cmpl_x = 1'b0;
    bus.cmpl_y = 1'b0;
    bus.carry_in = 1'b0;
    bus.end_bar = 1'b1;
    bus.op_and = 1'b0;
    bus.op_xor = 1'b0;
    bus.op_arith = 1'b0;

    // model pins
    p = calc(8'h7F, 8'h01, 0, 0, 0, 1, 0, 0);
    chk("pin_ovf_z", p.z, 8'h80);
    chk("pin_ovf_ov", p.ov, 1);
    p = calc(8'h05, 8'h03, 0, 1, 1, 1, 0, 0);
    chk("pin_sub_z", p.z, 8'h02);
    chk("pin_sub_co", p.co, 1);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", bus.in_ready, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_zout", bus.zout, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", bus.in_ready, 1);
    idle(1);

    // signed overflow
    obs_q.delete();
    send(8'h7F, 8'h01, 0, 0, 0, 1, 1, 0, 0);
    idle(8);
    chk("ovf_count", obs_q.size(), 1);
    if (obs_q.size() >= 1) begin
      chk("ovf_z", obs_q[0].r.z, 8'h80);
      chk("ovf_ov", obs_q[0].r.ov, 1);
      chk("ovf_co", obs_q[0].r.co, 0);
    end

    // subtract
    obs_q.delete();
    send(8'h05, 8'h03, 0, 1, 1, 1, 1, 0, 0);
    idle(8);
    chk("sub_count", obs_q.size(), 1);
    if (obs_q.size() >= 1) begin
      chk("sub_z", obs_q[0].r.z, 8'h02);
      chk("sub_co", obs_q[0].r.co, 1);
      chk("sub_ov", obs_q[0].r.ov, 0);
    end

    // back-to-back
    obs_q.delete();
    send(8'hF0, 8'h3C, 0, 0, 0, 1, 0, 0, 1);
    send(8'hF0, 8'h3C, 0, 0, 0, 1, 0, 1, 0);
    send(8'h10, 8'h20, 0, 0, 0, 1, 1, 0, 0);
    idle(8);
    chk("b2b_count", obs_q.size(), 3);
    if (obs_q.size() >= 3) begin
      chk("b2b_z0", obs_q[0].r.z, 8'h30);
      chk("b2b_z1", obs_q[1].r.z, 8'hCC);
      chk("b2b_z2", obs_q[2].r.z, 8'h30);
      chk("b2b_span", obs_q[2].t - obs_q[0].t, 2);
    end

    // chaining
    obs_q.delete();
    low_cnt = 0;
    send(8'hFF, 8'h01, 0, 0, 0, 0, 1, 0, 0);
    send(8'h00, 8'h00, 0, 0, 0, 1, 1, 0, 0);
    idle(8);
    chk("chain_stall", low_cnt, 5);
    chk("chain_count", obs_q.size(), 2);
    if (obs_q.size() >= 2) begin
      chk("chain_z0", obs_q[0].r.z, 8'h00);
      chk("chain_co0", obs_q[0].r.co, 1);
      chk("chain_z1", obs_q[1].r.z, 8'h01);
      chk("chain_co1", obs_q[1].r.co, 0);
    end

    // reset mid-flight
    obs_q.delete();
    send(8'h11, 8'h22, 0, 0, 0, 1, 1, 0, 0);
    send(8'h33, 8'h0F, 0, 0, 0, 1, 0, 1, 0);
    send(8'hAA, 8'hFF, 0, 0, 0, 1, 0, 0, 1);
    idle(1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_ready", bus.in_ready, 1);
    chk("mid_zout", bus.zout, 0);
    chk("mid_co", bus.carry_out, 0);
    chk("mid_ov", bus.overflow, 0);
    idle(8);
    chk("mid_count", obs_q.size(), 0);

`ifdef ALU_PIPE_ZERO_FLAG_EN
    obs_q.delete();
    send(8'h5A, 8'h5A, 0, 0, 0, 1, 0, 1, 0);
    send(8'h01, 8'h01, 0, 0, 0, 1, 0, 0, 1);
    idle(8);
    chk("zf_count", obs_q.size(), 2);
    if (obs_q.size() >= 2) begin
      chk("zf_z0", obs_q[0].r.z, 8'h00);
      chk("zf_f0", obs_q[0].zf, 1);
      chk("zf_f1", obs_q[1].zf, 0);
    end
`endif

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic ar;
      logic eb;
      ar = ($urandom_range(0, 2) == 0);
      eb = ($urandom_range(0, 3) != 0);
      send(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), eb, ar, 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      if (i == 150) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
    end
    idle(10);
    chk("drained", exp_at.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
